// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and constants for the APB master bridge:
//                bus widths, slave-index width, address-region bit fields
//                and the bridge state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int SLAVE_IDX_W = 3;
    localparam int MAX_SLAVES  = 8;

    // Region tag: upper half of the address must match the APB base.
    localparam int REGION_MSB  = 31;
    localparam int REGION_LSB  = 16;

    // Slave slot: one 4 KiB window per peripheral.
    localparam int IDX_MSB     = 15;
    localparam int IDX_LSB     = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : apb_addr_decoder
//  Description : Combinational address decode for the APB bridge. Reports a
//                hit when the address lies in the APB region and its 4 KiB
//                slot number is below NUM_SLAVES; the slot is the slave index.
//  Ports       : i_addr  - address bits [31:12] (page offset is irrelevant)
//                o_hit   - address maps to an existing slave
//                o_index - slave index (meaningful only when o_hit=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic [APB_ADDR_W-1:IDX_LSB] i_addr,
    output logic                        o_hit,
    output logic [SLAVE_IDX_W-1:0]      o_index
);

    localparam logic [3:0] c_num_slots = 4'(NUM_SLAVES);

    logic       w_region_ok;
    logic [3:0] w_slot;

    assign w_region_ok = (i_addr[REGION_MSB:REGION_LSB] == BASE_ADDR[REGION_MSB:REGION_LSB]);
    assign w_slot      = i_addr[IDX_MSB:IDX_LSB];

    // The full 4-bit slot is compared so slots 8..15 never alias onto 0..7.
    assign o_hit   = w_region_ok && (w_slot < c_num_slots);
    assign o_index = w_slot[SLAVE_IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : Converts single-beat CPU load/store requests into APB
//                transfers to up to 8 slaves. Unmapped addresses complete
//                immediately with an error; a slave that never raises PREADY
//                is abandoned after TIMEOUT access cycles with an error.
//  Ports       : PCLK, PRESET      - clock, asynchronous active-high reset
//                i_transfer        - request strobe (sampled in IDLE only)
//                i_write/i_addr/i_wdata - request attributes
//                o_rdata/o_ready/o_err  - one-cycle completion response
//                o_paddr/o_pwdata/o_pwrite/o_penable/o_psel - APB master side
//                i_prdata_s/i_pready_s  - per-slave APB return paths
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          TIMEOUT    = 255
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    // CPU side
    input  logic                             i_transfer,
    input  logic                             i_write,
    input  logic [APB_ADDR_W-1:0]            i_addr,
    input  logic [APB_DATA_W-1:0]            i_wdata,
    output logic [APB_DATA_W-1:0]            o_rdata,
    output logic                             o_ready,
    output logic                             o_err,
    // APB side
    output logic [APB_ADDR_W-1:0]            o_paddr,
    output logic [APB_DATA_W-1:0]            o_pwdata,
    output logic                             o_pwrite,
    output logic                             o_penable,
    output logic [NUM_SLAVES-1:0]            o_psel,
    input  logic [APB_DATA_W*NUM_SLAVES-1:0] i_prdata_s,
    input  logic [NUM_SLAVES-1:0]            i_pready_s
);

    // Wait counter is at least 8 bits, wider if TIMEOUT needs it.
    localparam int c_cnt_w = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_timeout  = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = {c_cnt_w{1'b1}};

    apb_state_e                r_state;
    logic [SLAVE_IDX_W-1:0]    r_idx;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [NUM_SLAVES-1:0]     r_psel;
    logic                      r_penable;
    logic [APB_ADDR_W-1:0]     r_paddr;
    logic [APB_DATA_W-1:0]     r_pwdata;
    logic                      r_pwrite;
    logic [APB_DATA_W-1:0]     r_rdata;
    logic                      r_ready;
    logic                      r_err;

    logic                      w_hit;
    logic [SLAVE_IDX_W-1:0]    w_dec_idx;
    logic [NUM_SLAVES-1:0]     w_req_onehot;
    logic                      w_sel_pready;
    logic [APB_DATA_W-1:0]     w_sel_prdata;

    // ------------------------------------------------------------------
    // Address decode of the incoming (not yet latched) request
    // ------------------------------------------------------------------
    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decoder (
        .i_addr  (i_addr[APB_ADDR_W-1:IDX_LSB]),
        .o_hit   (w_hit),
        .o_index (w_dec_idx)
    );

    always_comb begin
        w_req_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_req_onehot[i] = (w_dec_idx == SLAVE_IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Return-path mux: only the latched slave's PREADY/PRDATA are seen,
    // so stray PREADY from unselected slaves has no effect.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_pready = 1'b0;
        w_sel_prdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == SLAVE_IDX_W'(i)) begin
                w_sel_pready = i_pready_s[i];
                w_sel_prdata = i_prdata_s[i*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM. Every output is a register so the APB bus and the
    // CPU response are glitch-free.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_rdata   <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (i_transfer) begin
                        r_paddr  <= i_addr;
                        r_pwdata <= i_wdata;
                        r_pwrite <= i_write;
                        r_idx    <= w_dec_idx;
                        if (w_hit) begin
                            // PSEL rises as SETUP is entered, one cycle
                            // after the request.
                            r_psel  <= w_req_onehot;
                            r_state <= ST_SETUP;
                        end else begin
                            // Unmapped: answer straight away, bus untouched.
                            r_rdata <= '0;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (w_sel_pready) begin
                        r_rdata   <= r_pwrite ? '0 : w_sel_prdata;
                        r_err     <= 1'b0;
                        r_ready   <= 1'b1;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (r_cnt == c_timeout) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_ready   <= 1'b1;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Response lasts exactly one cycle; IDLE follows so PSEL
                    // stays low for at least two cycles between transfers.
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rdata   = r_rdata;
    assign o_ready   = r_ready;
    assign o_err     = r_err;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;
    assign o_pwrite  = r_pwrite;
    assign o_penable = r_penable;
    assign o_psel    = r_psel;

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
# apb_master_bridge

Converts single-beat CPU load/store requests into APB transfers and fans them out to up to 8 peripherals (UART, GPIO, timer, …) via a fixed address decode. Sits between the CPU data bus and the APB slave interfaces, driving shared PADDR/PWDATA/PWRITE/PENABLE, one PSEL per slave, and muxing the slave PRDATA/PREADY back. Adds an unmapped-address error and a PREADY timeout so a dead slave cannot hang the CPU.

## Interface
- NUM_SLAVES, 4: number of PSEL lines (1–8).
- BASE_ADDR, 32'h1000_0000: APB region base; addr[31:16] must equal BASE_ADDR[31:16].
- TIMEOUT, 255: max ACCESS cycles waiting for PREADY before error.
- PCLK  in  1  clock.
- PRESET  in  1  reset, asynchronous, active-high.
- transfer  in  1  CPU request strobe, sampled in IDLE only.
- write  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  valid with ready; 1 = unmapped address or timeout.
- PADDR  out  32  latched addr.
- PWDATA  out  32  latched wdata.
- PWRITE  out  1  latched write.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA_S  in  32*NUM_SLAVES  slave read data, slave i at [32i+31:32i].
- PREADY_S  in  NUM_SLAVES  slave ready.

## Operation
- Decode: hit when addr[31:16]==BASE_ADDR[31:16] and addr[15:12] < NUM_SLAVES; slave index = addr[15:12]. Otherwise miss.
- States IDLE, SETUP, ACCESS, DONE.
- IDLE: transfer=1 latches addr/wdata/write/index. Hit -> SETUP. Miss -> DONE with err=1, no PSEL ever raised, rdata=0.
- SETUP: PSEL[index]=1, PENABLE=0, timeout counter cleared -> ACCESS.
- ACCESS: PSEL[index]=1, PENABLE=1. PREADY_S[index]=1 -> capture PRDATA_S[index] (reads; 0 on writes), err=0 -> DONE. Counter reaches TIMEOUT without PREADY -> DONE, err=1, rdata=0.
- DONE: ready=1 one cycle, PSEL=0, PENABLE=0 -> IDLE.
- transfer outside IDLE ignored; requester holds nothing after acceptance.
- PREADY_S of unselected slaves ignored.
- Reset: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, counter=0. Reset mid-transfer aborts immediately; no ready issued.

## Timing
- All outputs registered.
- Zero-wait slave: transfer@T0 -> PSEL@T1 -> PENABLE@T2 -> PREADY sampled @T2 -> ready@T3. Latency = 3 + wait states.
- Slave with registered PREADY (one wait): ready@T4.
- Miss: ready/err@T1.
- Timeout: ready/err exactly TIMEOUT+3 cycles after transfer.
- PADDR/PWDATA/PWRITE stable from SETUP through ACCESS; PSEL and PENABLE drop together in DONE.
- Back-to-back: new transfer accepted in the IDLE cycle after DONE; PSEL low at least 2 cycles between transfers (DONE, IDLE).
- Counter 8 bits wide min, saturating; no wrap.

## Structure
- Package apb_pkg: state enum, APB_ADDR_W=32, APB_DATA_W=32, SLAVE_IDX_W=3, region constants.
- Sub-module apb_addr_decoder: combinational addr -> hit, index; bridge holds FSM, latches, counter, muxes.

## Test plan
- Write 0x1000_1008 data 0x0000_0041 to slave1 with zero-wait PREADY -> PSEL=4'b0010 @T1, PENABLE @T2, PWDATA=0x41, ready@T3, err=0.
- Read 0x1000_000C from slave0 with one wait state, PRDATA_S[0]=0x5A -> rdata=0x0000_005A, ready@T4, err=0.
- Read 0x2000_0000 and 0x1000_7000 -> ready@T1, err=1, rdata=0, PSEL never asserted.
- Slave2 never raises PREADY, TIMEOUT=16 -> ready with err=1 at T19, PSEL cleared after.
- Two back-to-back writes to slave3 with transfer held high -> two separate PSEL windows, second PSEL@T5, no overlap, both ready with err=0.
- PRESET asserted in ACCESS -> PSEL/PENABLE/ready zero same cycle, next transfer completes normally.
